mem_stage: RTL

Memory-stage access controller for the pipelined core. Sits between the EX/MEM pipeline register and the MEM/WB register. It issues data-cache requests for the instruction held in EX/MEM and waits for `dhit`. It returns load data and the writeback value, and raises `memW` so MEM/WB captures the result. It also maintains the LL/SC link register, including invalidation from coherence snoops.

---
 rtl/mem_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-stage access controller: issues dcache requests for EX/MEM and tracks the LL/SC link register.
// Latency: a hit completes in the issue cycle; a miss completes on the dhit cycle; a frozen completion waits in DONE.
// Backpressure: memStall holds the earlier stages until the access completes and MEM/WB is unfrozen.
module mem_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        memMemRead,
    input  logic        memMemWrite,
    input  logic        memLL,
    input  logic        memSC,
    input  logic [31:0] memALUOutput,
    input  logic [31:0] memStoreData,
    input  logic        pipeFreeze,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] memdmemload,
    output logic [31:0] memOutput_Port,
    output logic        memW,
    output logic        memStall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        llvalid_q, llvalid_d;
    logic [31:0] lladdr_q, lladdr_d;
    logic [31:0] dbuf_q, dbuf_d;

    logic        sc_fail;
    logic        mem_op;
    logic        req;
    logic        complete;
    logic        memw_c;
    logic        stall_c;
    logic [31:0] load_c;
    logic        snoop_hit;
    logic        store_hit;
    logic        unused_addr_bits;

    // Byte offsets play no part in link matching.
    assign unused_addr_bits = ^{ccsnoopaddr[1:0], lladdr_q[1:0]};

    always_comb begin
        sc_fail = memSC && (!llvalid_q || (lladdr_q[31:2] != memALUOutput[31:2]));
        mem_op  = (memMemRead || memMemWrite) && !sc_fail;
    end

    always_comb begin
        state_d  = state_q;
        dbuf_d   = dbuf_q;
        req      = 1'b0;
        complete = 1'b0;
        memw_c   = 1'b0;
        stall_c  = 1'b0;
        load_c   = 32'd0;
        unique case (state_q)
            IDLE, WAIT: begin
                if (state_q == WAIT || mem_op) begin
                    req     = 1'b1;
                    stall_c = 1'b1;
                    if (dhit) begin
                        complete = 1'b1;
                        if (pipeFreeze) begin
                            dbuf_d  = dmemload;
                            state_d = DONE;
                        end else begin
                            memw_c  = 1'b1;
                            stall_c = 1'b0;
                            load_c  = dmemload;
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    memw_c = !pipeFreeze;
                end
            end
            DONE: begin
                // Access already finished; only waiting for MEM/WB to unfreeze.
                stall_c = 1'b1;
                load_c  = dbuf_q;
                if (!pipeFreeze) begin
                    memw_c  = 1'b1;
                    stall_c = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        llvalid_d = llvalid_q;
        lladdr_d  = lladdr_q;
        snoop_hit = ccinv && (ccsnoopaddr[31:2] == lladdr_q[31:2]);
        store_hit = complete && memMemWrite &&
                    (memSC || (memALUOutput[31:2] == lladdr_q[31:2]));
        if (snoop_hit || store_hit) begin
            llvalid_d = 1'b0;
        end
        // A completing LL overrides any same-cycle invalidation.
        if (complete && memMemRead && memLL) begin
            llvalid_d = 1'b1;
            lladdr_d  = memALUOutput;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= IDLE;
            llvalid_q <= 1'b0;
            lladdr_q  <= 32'd0;
            dbuf_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            llvalid_q <= llvalid_d;
            lladdr_q  <= lladdr_d;
            dbuf_q    <= dbuf_d;
        end
    end

    always_comb begin
        dmemaddr       = memALUOutput;
        dmemstore      = memStoreData;
        dmemREN        = nRST && req && memMemRead;
        dmemWEN        = nRST && req && memMemWrite && !memMemRead;
        memW           = nRST && memw_c;
        memStall       = nRST && stall_c;
        memdmemload    = nRST ? load_c : 32'd0;
        memOutput_Port = 32'd0;
        if (nRST) begin
            if (memSC) begin
                // Once past IDLE the SC has already been judged successful.
                memOutput_Port = {31'd0, (state_q != IDLE) || !sc_fail};
            end else begin
                memOutput_Port = memALUOutput;
            end
        end
    end

endmodule
